// File: rtl/pio_poll_sched_if.sv
// Bus bundle for pio_poll_sched: the shared PIO read port it masters plus the
// Avalon-MM CSR slave port it exposes to the CPU.
interface pio_poll_sched_if;
  // PIO read port
  logic [2:0]  poll_sel;
  logic [1:0]  poll_address;
  logic        poll_read;
  logic [31:0] poll_readdata;
  // CSR slave port
  logic [1:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;

  // Scheduler side
  modport master (
    output poll_sel,
    output poll_address,
    output poll_read,
    input  poll_readdata,
    input  csr_address,
    input  csr_read,
    input  csr_write,
    input  csr_writedata,
    output csr_readdata
  );

  // Environment side: PIO mux and CPU
  modport slave (
    input  poll_sel,
    input  poll_address,
    input  poll_read,
    output poll_readdata,
    output csr_address,
    output csr_read,
    output csr_write,
    output csr_writedata,
    input  csr_readdata
  );
endinterface

// File: rtl/pio_poll_sched.sv
// pio_poll_sched: round-robin poller for single-bit PIO slaves. Each sample goes
// through a per-port consecutive-sample debounce; accepted level changes set
// sticky EDGE bits that drive a maskable level interrupt via a 4-word CSR map.
module pio_poll_sched #(
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned STABLE_COUNT  = 3,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_poll_sched_if.master bus,
  output logic             irq
);

  localparam logic [2:0]  LastIdx  = 3'(NUM_PORTS - 1);
  // A differing sample arriving with the count at this value is the accepting one.
  localparam logic [3:0]  AcceptAt = 4'(STABLE_COUNT - 1);
  localparam logic [15:0] IntvLast = 16'(POLL_INTERVAL - 1);

  localparam logic [1:0] AddrStatus = 2'd0;
  localparam logic [1:0] AddrEdge   = 2'd1;
  localparam logic [1:0] AddrMask   = 2'd2;
  localparam logic [1:0] AddrCtrl   = 2'd3;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [15:0]                 intv_q, intv_d;
  logic                        primed_q, primed_d;
  logic                        poll_read_q, poll_read_d;
  logic [2:0]                  poll_sel_q, poll_sel_d;
  logic                        capture;

  logic [NUM_PORTS-1:0]        level_q, level_d;
  logic [NUM_PORTS-1:0][3:0]   cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]        edge_q, edge_d;
  logic [NUM_PORTS-1:0]        edge_set;
  logic [NUM_PORTS-1:0]        edge_clr;
  logic [NUM_PORTS-1:0]        mask_q, mask_d;
  logic                        enable_q, enable_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic                        irq_q, irq_d;
  logic                        raw;

  assign raw = bus.poll_readdata[0];

  // Only bit 0 of the PIO data and the low CSR data bits carry information.
  logic unused_bits;
  assign unused_bits = ^{bus.poll_readdata[31:1], bus.csr_writedata[31:NUM_PORTS]};

  // Poll sequencer next state: idle interval, then ISSUE/CAPTURE per port.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    intv_d   = intv_q;
    primed_d = primed_q;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!enable_q) begin
          intv_d = '0;
        end else if (intv_q == IntvLast) begin
          intv_d  = '0;
          idx_d   = '0;
          state_d = StIssue;
        end else begin
          intv_d = intv_q + 16'd1;
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        capture = 1'b1;
        if (idx_q == LastIdx) begin
          state_d  = StIdle;
          idx_d    = '0;
          primed_d = 1'b1;
        end else if (!enable_q) begin
          // Disable only takes effect between ports; next sweep restarts at 0.
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StIssue;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
    poll_read_d = (state_d == StIssue);
    poll_sel_d  = idx_d;
  end

  // Sequencer state and registered poll-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      intv_q      <= '0;
      primed_q    <= 1'b0;
      poll_read_q <= 1'b0;
      poll_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      intv_q      <= intv_d;
      primed_q    <= primed_d;
      poll_read_q <= poll_read_d;
      poll_sel_q  <= poll_sel_d;
    end
  end

  // Per-port debounce, applied only on that port's CAPTURE cycle.
  always_comb begin
    level_d  = level_q;
    cnt_d    = cnt_q;
    edge_set = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (capture && (idx_q == 3'(i))) begin
        if (!primed_q) begin
          // First sweep only establishes the baseline level.
          level_d[i] = raw;
          cnt_d[i]   = '0;
        end else if (raw == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= AcceptAt) begin
          level_d[i]  = raw;
          edge_set[i] = 1'b1;
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // CSR write decode, read mux and interrupt next state.
  always_comb begin
    edge_clr = '0;
    mask_d   = mask_q;
    enable_d = enable_q;
    if (bus.csr_write) begin
      unique case (bus.csr_address)
        AddrEdge: edge_clr = bus.csr_writedata[NUM_PORTS-1:0];
        AddrMask: mask_d   = bus.csr_writedata[NUM_PORTS-1:0];
        AddrCtrl: enable_d = bus.csr_writedata[0];
        default:  ;
      endcase
    end
    // A capture setting a bit beats a same-cycle write-1-to-clear.
    edge_d = (edge_q & ~edge_clr) | edge_set;

    rdata_d = rdata_q;
    if (bus.csr_read) begin
      unique case (bus.csr_address)
        AddrStatus: rdata_d = 32'(level_q);
        AddrEdge:   rdata_d = 32'(edge_q);
        AddrMask:   rdata_d = 32'(mask_q);
        AddrCtrl:   rdata_d = {30'd0, primed_q, enable_q};
        default:    rdata_d = '0;
      endcase
    end

    irq_d = |(edge_q & mask_q);
  end

  // Debounce state, CSR registers and registered CSR/irq outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      enable_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      enable_q <= enable_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.poll_sel     = poll_sel_q;
  assign bus.poll_address = 2'b00;
  assign bus.poll_read    = poll_read_q;
  assign bus.csr_readdata = rdata_q;
  assign irq              = irq_q;

endmodule

// File: tb/tb_pio_poll_sched.sv
// Bench for pio_poll_sched: directed scenarios followed by randomized sweeps,
// checked against a per-sweep reference model of levels, EDGE, MASK and irq.
module tb_pio_poll_sched;
  localparam int NP = 4;
  localparam int SC = 3;
  localparam int PI = 16;
  localparam int P  = PI + 2 * NP;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;

  pio_poll_sched_if bus_if ();

  pio_poll_sched #(
    .NUM_PORTS    (NP),
    .STABLE_COUNT (SC),
    .POLL_INTERVAL(PI)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // External PIO bank + mux: readdata registered one cycle after the select,
  // upper bits are noise the DUT must ignore.
  logic [7:0] pin = '0;
  always @(posedge clk) begin
    logic [31:0] r;
    r = $urandom;
    r[0] = pin[bus_if.poll_sel];
    bus_if.poll_readdata <= r;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  bit sched_on = 1'b0;

  // Reference model state
  logic [NP-1:0] mlev, medge, mmask;
  int            mcnt [NP];
  bit            mprimed, menable;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mlev = '0;
    medge = '0;
    mmask = '0;
    mprimed = 1'b0;
    menable = 1'b0;
    for (int i = 0; i < NP; i++) mcnt[i] = 0;
  endtask

  // One edge; then, when enabled, compare poll strobes against the fixed
  // schedule: PI idle cycles, then sel 0..NP-1 on every other cycle, period P.
  task automatic tick();
    int d;
    int ph;
    logic er;
    logic [2:0] es;
    @(posedge clk);
    cyc++;
    #1;
    if (sched_on) begin
      d = cyc - base - PI;
      er = 1'b0;
      es = '0;
      if (d >= 0) begin
        ph = d % P;
        if (ph < 2 * NP && ph % 2 == 0) begin
          er = 1'b1;
          es = 3'(ph / 2);
        end
      end
      check("sched_read", 32'(bus_if.poll_read), 32'(er));
      if (er) begin
        check("sched_sel", 32'(bus_if.poll_sel), 32'(es));
        check("sched_addr", 32'(bus_if.poll_address), 32'd0);
      end
    end
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) check("wait_order", cyc, t);
    while (cyc < t) tick();
  endtask

  function automatic int end_of(input int k);
    return base + PI + P * k + 2 * NP;
  endfunction

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.csr_address = a;
    bus_if.csr_writedata = d;
    bus_if.csr_write = 1'b1;
    tick();
    bus_if.csr_write = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.csr_address = a;
    bus_if.csr_read = 1'b1;
    tick();
    d = bus_if.csr_readdata;
    bus_if.csr_read = 1'b0;
  endtask

  // Debounce rule applied to the first lim ports with the current pin levels.
  task automatic apply_sweep(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (!mprimed) begin
        mlev[i] = pin[i];
        mcnt[i] = 0;
      end else if (pin[i] == mlev[i]) begin
        mcnt[i] = 0;
      end else begin
        mcnt[i]++;
        if (mcnt[i] == SC) begin
          mlev[i] = pin[i];
          medge[i] = 1'b1;
          mcnt[i] = 0;
        end
      end
    end
    if (lim == NP) mprimed = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    tick();
    check({tag, "_irq"}, 32'(irq), 32'(|(medge & mmask)));
    csr_read(2'd0, d);
    check({tag, "_status"}, d, 32'(mlev));
    csr_read(2'd1, d);
    check({tag, "_edge"}, d, 32'(medge));
    csr_read(2'd2, d);
    check({tag, "_mask"}, d, 32'(mmask));
    csr_read(2'd3, d);
    check({tag, "_ctrl"}, d, {30'd0, mprimed, menable});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_read"}, 32'(bus_if.poll_read), 32'd0);
    check({tag, "_sel"}, 32'(bus_if.poll_sel), 32'd0);
    check({tag, "_addr"}, 32'(bus_if.poll_address), 32'd0);
    check({tag, "_rdata"}, bus_if.csr_readdata, 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] w;
    logic        exp_irq;
    int          c;
    int          pr;

    bus_if.csr_address = '0;
    bus_if.csr_read = 1'b0;
    bus_if.csr_write = 1'b0;
    bus_if.csr_writedata = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick();
    csr_read(2'd3, d);
    check("reset_ctrl", d, 32'd0);
    csr_read(2'd0, d);
    check("reset_status", d, 32'd0);

    // Port 2 high before enable; priming must not raise an edge. CTRL bit1 is RO.
    pin[2] = 1'b1;
    csr_write(2'd3, 32'h3);
    menable = 1'b1;
    base = cyc;
    sched_on = 1'b1;
    csr_read(2'd3, d);
    check("ctrl_unprimed", d, 32'h1);
    wait_until(end_of(0));
    apply_sweep(NP);
    check_regs("sweep0");
    tick();
    check("rdata_hold", bus_if.csr_readdata, {30'd0, mprimed, menable});

    // Port 1 rises with MASK=0x2 (upper write bits ignored)
    csr_write(2'd2, 32'hFFFF_FFF2);
    mmask = 4'h2;
    pin[1] = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      wait_until(end_of(k));
      apply_sweep(NP);
      check_regs($sformatf("rise_s%0d", k));
    end
    pin[0] = 1'b1;  // glitch on port 0 for sweeps 3 and 4
    wait_until(end_of(3));
    apply_sweep(NP);
    check_regs("rise_s3");
    exp_irq = |(medge & mmask);
    csr_write(2'd1, 32'h2);
    medge[1] = 1'b0;
    check("irq_lag", 32'(irq), 32'(exp_irq));
    tick();
    check("irq_clr", 32'(irq), 32'(|(medge & mmask)));
    csr_read(2'd1, d);
    check("edge_clr", d, 32'(medge));

    wait_until(end_of(4));
    apply_sweep(NP);
    pin[0] = 1'b0;
    check_regs("glitch_s4");
    wait_until(end_of(5));
    apply_sweep(NP);
    check_regs("glitch_s5");

    // Port 3 accepted on the same edge that a write-1-clear of bit 3 lands
    pin[3] = 1'b1;
    csr_write(2'd2, 32'hA);
    mmask = 4'hA;
    for (int k = 6; k <= 7; k++) begin
      wait_until(end_of(k));
      apply_sweep(NP);
      check_regs($sformatf("p3_s%0d", k));
    end
    wait_until(end_of(8) - 1);
    csr_write(2'd1, 32'h8);
    medge[3] = 1'b0;
    apply_sweep(NP);
    check_regs("w1c_race");

    // Port 1 falls; enable dropped during port 1 ISSUE of sweep 11
    pin[1] = 1'b0;
    for (int k = 9; k <= 10; k++) begin
      wait_until(end_of(k));
      apply_sweep(NP);
      check_regs($sformatf("fall_s%0d", k));
    end
    c = base + PI + P * 11 + 2;
    wait_until(c);
    check("dis_issue_read", 32'(bus_if.poll_read), 32'd1);
    check("dis_issue_sel", 32'(bus_if.poll_sel), 32'd1);
    sched_on = 1'b0;
    csr_write(2'd3, 32'h0);
    menable = 1'b0;
    pr = 0;
    repeat (40) begin
      tick();
      if (bus_if.poll_read) pr++;
    end
    check("dis_no_read", pr, 0);
    apply_sweep(2);
    check_regs("disabled");

    // Re-enable: sweeps restart at sel 0, then randomized traffic
    csr_write(2'd3, 32'hFFFF_FFFF);
    menable = 1'b1;
    base = cyc;
    sched_on = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_until(end_of(k));
      apply_sweep(NP);
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(3) == 0) pin[i] = ~pin[i];
      end
      if ($urandom_range(2) == 0) begin
        w = $urandom;
        csr_write(2'd2, w);
        mmask = w[NP-1:0];
      end
      if ($urandom_range(2) == 0) begin
        w = $urandom;
        csr_write(2'd1, w);
        medge = medge & ~w[NP-1:0];
      end
      check_regs($sformatf("rnd_s%0d", k));
    end

    // Reset in the middle of a sweep (port 2 ISSUE)
    c = base + PI + P * 20 + 4;
    wait_until(c);
    check("pre_reset_read", 32'(bus_if.poll_read), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    sched_on = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    check_regs("post_reset");
    pr = 0;
    repeat (30) begin
      tick();
      if (bus_if.poll_read) pr++;
    end
    check("post_reset_idle", pr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_poll_sched.md
# pio_poll_sched

Polling scheduler and debounce controller for the bank of single-bit input PIO slaves (reset, button and status inputs) on the CPU subsystem. It sequences round-robin reads of up to 8 PIO slaves over a shared read port. Each sample passes through a per-port consecutive-sample debounce. Level changes are latched into a CPU-visible edge-capture register that drives a maskable interrupt through a 4-word Avalon-MM CSR slave.

## Interface
- NUM_PORTS, 4, number of polled PIO slaves, legal 1..8
- STABLE_COUNT, 3, consecutive differing samples needed to accept a level change, legal 1..15
- POLL_INTERVAL, 16, idle cycles between sweeps, legal 1..65535
- clk  in  1  single system clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- poll_sel  out  3  index of PIO slave being read; external mux routes its readdata back
- poll_address  out  2  PIO register address; always 0 (data register)
- poll_read  out  1  read strobe to selected PIO, one cycle per port
- poll_readdata  in  32  readdata of selected PIO; only bit 0 used
- csr_address  in  2  CSR word address
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, registered
- irq  out  1  level interrupt, registered

## Operation
- CSR map: 0 STATUS (RO, bits[NUM_PORTS-1:0] = debounced levels); 1 EDGE (bits set on accepted change, write-1-to-clear); 2 MASK (RW irq mask); 3 CTRL (RW, bit0 = enable, bit1 = primed RO). Unused bits read 0; writes to RO bits are ignored.
- irq = |(EDGE & MASK), registered.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: interval counter counts up while enable=1. On reaching POLL_INTERVAL-1, go to ISSUE with port index 0. Counter clears on exit and whenever enable=0.
- ISSUE: poll_read=1, poll_sel=index, poll_address=0. Next state is CAPTURE.
- CAPTURE: sample poll_readdata[0] as raw[index]. If index=NUM_PORTS-1, go to IDLE, set primed=1; otherwise index+1 and go to ISSUE.
- Debounce (per port, applied on its CAPTURE):
  - not primed: level := raw, count := 0, no edge.
  - primed, raw == level: count := 0.
  - primed, raw != level: count+1. If count+1 == STABLE_COUNT, level := raw, EDGE[i] := 1, count := 0.
- Counters are 4-bit and saturate; they cannot exceed STABLE_COUNT.
- enable cleared mid-sweep: the current port's ISSUE/CAPTURE pair completes, then the FSM returns to IDLE. The next sweep restarts at index 0. primed is retained.
- Simultaneous EDGE set and write-1-clear on the same bit: set wins.
- Port index is never ≥ NUM_PORTS.

## Timing
- Reset values: poll_sel=0, poll_address=0, poll_read=0, csr_readdata=0, irq=0. Also cleared: levels, EDGE, MASK, CTRL (enable=0, primed=0), counters, FSM=IDLE.
- The PIO registers readdata one cycle after address. poll_read is asserted in cycle t, and bit 0 is sampled at the end of cycle t+1 (CAPTURE).
- Sweep length: 2*NUM_PORTS cycles. Sweep period: POLL_INTERVAL + 2*NUM_PORTS cycles.
- CSR read latency: 1 cycle. csr_readdata updates on the edge after csr_read and holds until the next read.
- CSR write takes effect on the edge of csr_write.
- irq reflects EDGE/MASK changes one cycle after the register update.
- Accepted change latency from input: between (STABLE_COUNT-1) sweep periods + 2 cycles and STABLE_COUNT sweep periods + 2 cycles.
- Reset asserted mid-sweep: immediate return to reset values. There is no pending read; the PIO ignores a dropped strobe.

## Test plan
- Reset, write CTRL=1, all inputs 0, NUM_PORTS=4, POLL_INTERVAL=16 -> poll_read pulses at sel 0,1,2,3 every 24 cycles. After the first sweep CTRL reads 0x3; STATUS=0, EDGE=0, irq=0.
- Port 2 held at 1 from before enable -> after first sweep STATUS=0x4, EDGE=0 (priming suppresses the edge).
- After priming, port 1 rises and stays high, MASK=0x2 -> EDGE=0x2 and irq=1 after the 3rd differing sweep. Write EDGE=0x2 -> EDGE=0, irq=0 next cycle.
- Port 0 glitch high for 2 sweeps then low, STABLE_COUNT=3 -> STATUS bit0 stays 0, EDGE stays 0.
- EDGE write-1-clear of bit 3 in the same cycle as port 3's accepted change -> EDGE bit3 remains 1.
- Clear enable during ISSUE of port 1 -> CAPTURE for port 1 still occurs, then no poll_read until re-enable. Next sweep starts at sel=0. Assert reset_n=0 mid-sweep -> all outputs 0 within the same cycle.
